// File: rtl/wb_uart_master_pkg.sv
// Shared definitions for the serial-to-Wishbone debug master.
// Holds the command/response byte codes, the FSM state encoding and a
// small byte shift helper used when assembling address and data words.
package wb_uart_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_OK    = 8'hA5;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_ADR = 3'd1,
    ST_GET_DAT = 3'd2,
    ST_WB      = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  // Appends a received byte to a 32-bit word, most significant byte first.
  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

endpackage

// File: rtl/wb_uart_master_if.sv
// Byte-stream and Wishbone signal bundle for wb_uart_master.
// master modport: the bridge (consumes rx bytes, produces tx bytes, drives Wishbone).
// slave modport : the environment (UART rx/tx side plus the Wishbone slave/interconnect).
//   rx_data/rx_valid     received byte strobe, no backpressure
//   tx_data/tx_valid/tx_ready  outgoing byte handshake
//   wb_*                 32-bit classic Wishbone single-cycle master signals
interface wb_uart_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i, wb_err_i,
    output tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i, wb_err_i,
    input  tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_uart_master.sv
// Serial debug bus master: assembles CMD/ADR/DAT frames from a UART byte
// stream, runs one Wishbone single read or write, and streams the reply back.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (drops any bus cycle at once)
//   bus      wb_uart_master_if.master: rx strobe, tx valid/ready, Wishbone master
//   busy     high whenever the FSM is not idle
// Parameters:
//   wb_timeout    cycles cyc/stb may stay high without ack/err before abort
//   byte_timeout  idle cycles allowed between bytes of one frame
module wb_uart_master
  import wb_uart_master_pkg::*;
#(
  parameter int unsigned wb_timeout   = 1024,
  parameter int unsigned byte_timeout = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  wb_uart_master_if.master bus,
  output logic             busy
);

  localparam int unsigned WB_W = $clog2(wb_timeout + 1);
  localparam int unsigned BT_W = $clog2(byte_timeout + 1);
  localparam logic [WB_W-1:0] WB_LAST = WB_W'(wb_timeout - 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(byte_timeout - 1);
  localparam logic [WB_W-1:0] WB_ONE  = WB_W'(1);
  localparam logic [BT_W-1:0] BT_ONE  = BT_W'(1);

  state_t          state_r;
  logic [2:0]      cnt_r;       // bytes received / bytes sent in current state
  logic            cmd_we_r;    // latched command type
  logic [31:0]     adr_r;
  logic [31:0]     dat_r;
  logic [31:0]     rsp_r;       // reply shifter, current byte in [31:24]
  logic [2:0]      rsp_len_r;
  logic [WB_W-1:0] wb_cnt_r;
  logic [BT_W-1:0] idle_cnt_r;
  logic            cyc_r;
  logic            we_r;
  logic [3:0]      sel_r;
  logic            tx_valid_r;
  logic            busy_r;

  logic            wb_done_s;
  logic [31:0]     wb_rsp_s;
  logic [2:0]      wb_len_s;

  // Bus termination decode: err dominates ack, timeout only when neither arrives.
  always_comb begin
    wb_done_s = 1'b0;
    wb_rsp_s  = {RSP_ERR, 24'h000000};
    wb_len_s  = 3'd1;
    if (bus.wb_err_i) begin
      wb_done_s = 1'b1;
    end else if (bus.wb_ack_i) begin
      wb_done_s = 1'b1;
      if (cmd_we_r) begin
        wb_rsp_s = {RSP_OK, 24'h000000};
      end else begin
        wb_rsp_s = bus.wb_dat_i;
        wb_len_s = 3'd4;
      end
    end else if (wb_cnt_r >= WB_LAST) begin
      wb_done_s = 1'b1;
    end else begin
      wb_done_s = 1'b0;
    end
  end

  // Frame FSM with datapath; every output is a register updated on transitions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      cmd_we_r   <= 1'b0;
      adr_r      <= 32'h0000_0000;
      dat_r      <= 32'h0000_0000;
      rsp_r      <= 32'h0000_0000;
      rsp_len_r  <= 3'd0;
      wb_cnt_r   <= '0;
      idle_cnt_r <= '0;
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      sel_r      <= 4'h0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.rx_valid && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ)) begin
            cmd_we_r   <= (bus.rx_data == CMD_WRITE);
            state_r    <= ST_GET_ADR;
            busy_r     <= 1'b1;
            cnt_r      <= 3'd0;
            idle_cnt_r <= '0;
          end
        end
        ST_GET_ADR, ST_GET_DAT: begin
          if (bus.rx_valid) begin
            idle_cnt_r <= '0;
            if (state_r == ST_GET_ADR) begin
              adr_r <= shift_in(adr_r, bus.rx_data);
            end else begin
              dat_r <= shift_in(dat_r, bus.rx_data);
            end
            if (cnt_r == 3'd3) begin
              cnt_r <= 3'd0;
              if (state_r == ST_GET_ADR && cmd_we_r) begin
                state_r <= ST_GET_DAT;
              end else begin
                state_r  <= ST_WB;
                cyc_r    <= 1'b1;
                we_r     <= cmd_we_r;
                sel_r    <= 4'hF;
                wb_cnt_r <= '0;
              end
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end else if (idle_cnt_r >= BT_LAST) begin
            // Host went quiet mid-frame: drop it without touching the bus.
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 3'd0;
          end else begin
            idle_cnt_r <= idle_cnt_r + BT_ONE;
          end
        end
        ST_WB: begin
          if (wb_done_s) begin
            cyc_r      <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= 4'h0;
            rsp_r      <= wb_rsp_s;
            rsp_len_r  <= wb_len_s;
            cnt_r      <= 3'd0;
            tx_valid_r <= 1'b1;
            state_r    <= ST_SEND;
          end else if (wb_cnt_r != {WB_W{1'b1}}) begin
            wb_cnt_r <= wb_cnt_r + WB_ONE;
          end
        end
        ST_SEND: begin
          if (tx_valid_r && bus.tx_ready) begin
            if (cnt_r == rsp_len_r - 3'd1) begin
              tx_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              cnt_r      <= 3'd0;
              state_r    <= ST_IDLE;
            end else begin
              rsp_r <= {rsp_r[23:0], 8'h00};
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cyc_r      <= 1'b0;
          we_r       <= 1'b0;
          sel_r      <= 4'h0;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          cnt_r      <= 3'd0;
        end
      endcase
    end
  end

  assign bus.tx_data  = rsp_r[31:24];
  assign bus.tx_valid = tx_valid_r;
  assign bus.wb_adr_o = adr_r;
  assign bus.wb_dat_o = dat_r;
  assign bus.wb_sel_o = sel_r;
  assign bus.wb_we_o  = we_r;
  assign bus.wb_cyc_o = cyc_r;
  assign bus.wb_stb_o = cyc_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_wb_uart_master.sv
// Directed bench for wb_uart_master: write, read, bus timeout, bus error,
// inter-byte framing timeout and asynchronous reset during a bus cycle.
module tb_wb_uart_master;
  import wb_uart_master_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  wb_uart_master_if bus ();

  wb_uart_master #(.wb_timeout(16), .byte_timeout(40)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
    if (cmd == 8'h01) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
  endtask

  // Slave responder: ack/err during the resp_at-th cyc cycle (-1 = never); n = cycles cyc was high.
  task automatic bus_cycle(input int resp_at, input logic use_err, input logic [31:0] rdata, output int n);
    n = 0;
    while (bus.wb_cyc_o === 1'b1 && n < 200) begin
      if (n == resp_at) begin
        bus.wb_dat_i = rdata;
        if (use_err) bus.wb_err_i = 1'b1;
        else bus.wb_ack_i = 1'b1;
      end
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      n++;
    end
  endtask

  // Collects reply bytes over a fixed window so extra or repeated bytes show up in cnt.
  task automatic get_reply(input bit rnd, output logic [31:0] got, output int cnt);
    logic       stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = 8'h00;
    got   = 32'h0;
    cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && bus.tx_valid === 1'b1) chk("tx_hold", {24'h0, bus.tx_data}, {24'h0, held});
      if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
        got = {got[23:0], bus.tx_data};
        cnt++;
      end
      stall = (bus.tx_valid === 1'b1) && !bus.tx_ready;
      held  = bus.tx_data;
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    int          n;
    int          cnt;
    int          seen;
    logic [31:0] got;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.wb_dat_i = 32'h0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    chk("rst_txv", {31'h0, bus.tx_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_adr", bus.wb_adr_o, 32'h0);
    chk("rst_sel", {28'h0, bus.wb_sel_o}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Write, ack after 2 cycles, reply A5
    send_cmd(CMD_WRITE, 32'h0000_1000, 32'hDEAD_BEEF);
    chk("wr_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    chk("wr_stb", {31'h0, bus.wb_stb_o}, 32'h1);
    chk("wr_adr", bus.wb_adr_o, 32'h0000_1000);
    chk("wr_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
    chk("wr_we", {31'h0, bus.wb_we_o}, 32'h1);
    chk("wr_sel", {28'h0, bus.wb_sel_o}, 32'hF);
    chk("wr_busy", {31'h0, busy}, 32'h1);
    bus_cycle(1, 1'b0, 32'h0, n);
    chk("wr_len", n, 32'd2);
    chk("wr_txv", {31'h0, bus.tx_valid}, 32'h1);
    get_reply(1'b0, got, cnt);
    chk("wr_rsp_n", cnt, 32'd1);
    chk("wr_rsp", got, 32'h0000_00A5);
    chk("wr_idle", {31'h0, busy}, 32'h0);

    // Read with randomly toggling tx_ready
    send_cmd(CMD_READ, 32'h4000_0004, 32'h0);
    chk("rd_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    chk("rd_adr", bus.wb_adr_o, 32'h4000_0004);
    chk("rd_we", {31'h0, bus.wb_we_o}, 32'h0);
    bus_cycle(2, 1'b0, 32'h1234_5678, n);
    chk("rd_len", n, 32'd3);
    get_reply(1'b1, got, cnt);
    chk("rd_rsp_n", cnt, 32'd4);
    chk("rd_rsp", got, 32'h1234_5678);
    chk("rd_idle", {31'h0, busy}, 32'h0);

    // Bus timeout: slave never answers
    send_cmd(CMD_READ, 32'h0000_0008, 32'h0);
    bus_cycle(-1, 1'b0, 32'h0, n);
    chk("to_len", n, 32'd16);
    get_reply(1'b0, got, cnt);
    chk("to_rsp_n", cnt, 32'd1);
    chk("to_rsp", got, 32'h0000_00EE);
    chk("to_idle", {31'h0, busy}, 32'h0);

    // Bus error on the first cycle
    send_cmd(CMD_WRITE, 32'h0000_000C, 32'h0000_0001);
    bus_cycle(0, 1'b1, 32'h0, n);
    chk("err_len", n, 32'd1);
    get_reply(1'b0, got, cnt);
    chk("err_rsp_n", cnt, 32'd1);
    chk("err_rsp", got, 32'h0000_00EE);

    // Framing: junk byte, then an abandoned partial frame
    send_byte(8'h55);
    @(negedge clk);
    chk("junk_busy", {31'h0, busy}, 32'h0);
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    send_byte(8'h10);
    chk("part_busy", {31'h0, busy}, 32'h1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.wb_cyc_o === 1'b1 || bus.tx_valid === 1'b1) seen++;
      @(negedge clk);
    end
    chk("drop_quiet", seen, 32'd0);
    chk("drop_busy", {31'h0, busy}, 32'h0);

    // Read with 30-cycle gaps between bytes (below the 40-cycle limit)
    send_byte(CMD_READ);
    for (int i = 3; i >= 0; i--) begin
      repeat (30) @(negedge clk);
      send_byte(8'h20 + 8'(i));
    end
    chk("gap_adr", bus.wb_adr_o, 32'h2322_2120);
    chk("gap_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    bus_cycle(0, 1'b0, 32'hA5A5_5A5A, n);
    get_reply(1'b0, got, cnt);
    chk("gap_rsp_n", cnt, 32'd4);
    chk("gap_rsp", got, 32'hA5A5_5A5A);

    // Asynchronous reset while cyc is high
    send_cmd(CMD_READ, 32'h0000_0010, 32'h0);
    chk("ar_cyc_pre", {31'h0, bus.wb_cyc_o}, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    chk("ar_stb", {31'h0, bus.wb_stb_o}, 32'h0);
    chk("ar_txv", {31'h0, bus.tx_valid}, 32'h0);
    chk("ar_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_cmd(CMD_READ, 32'h0000_0014, 32'h0);
    chk("ar_rd_adr", bus.wb_adr_o, 32'h0000_0014);
    bus_cycle(0, 1'b0, 32'hCAFE_F00D, n);
    chk("ar_rd_len", n, 32'd1);
    get_reply(1'b1, got, cnt);
    chk("ar_rsp_n", cnt, 32'd4);
    chk("ar_rsp", got, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
